// File: rtl/mix_columns_sequencer_pkg.sv
// Shared constants, FSM encoding and byte/coefficient helpers for the
// MixColumns sequencer.
package mix_columns_sequencer_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam logic [7:0] FWD_COEF0 = 8'h02;
    localparam logic [7:0] FWD_COEF1 = 8'h03;
    localparam logic [7:0] FWD_COEF2 = 8'h01;
    localparam logic [7:0] FWD_COEF3 = 8'h01;

    localparam logic [7:0] INV_COEF0 = 8'h0E;
    localparam logic [7:0] INV_COEF1 = 8'h0B;
    localparam logic [7:0] INV_COEF2 = 8'h0D;
    localparam logic [7:0] INV_COEF3 = 8'h09;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Circulant coefficient for a term whose distance from the output row is idx.
    function automatic logic [7:0] coef_sel(input logic inv, input logic [1:0] idx);
        logic [7:0] coef;
        case ({inv, idx})
            3'b000:  coef = FWD_COEF0;
            3'b001:  coef = FWD_COEF1;
            3'b010:  coef = FWD_COEF2;
            3'b011:  coef = FWD_COEF3;
            3'b100:  coef = INV_COEF0;
            3'b101:  coef = INV_COEF1;
            3'b110:  coef = INV_COEF2;
            3'b111:  coef = INV_COEF3;
            default: coef = 8'h00;
        endcase
        return coef;
    endfunction

    // Byte 0 sits in the most significant lane.
    function automatic logic [7:0] byte_at(input logic [127:0] st, input logic [3:0] idx);
        return st[{4'd15 - idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gf_reduce11.sv
// Folds an 11-bit carry-less product back into GF(2^8), top bit first.
module gf_reduce11
    import mix_columns_sequencer_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic [10:0] product_i,
    output logic [7:0]  reduced_o
);

    logic [9:0] fold10_s;
    logic [8:0] fold9_s;

    assign fold10_s  = product_i[9:0] ^ ({POLY, 2'b00} & {10{product_i[10]}});
    assign fold9_s   = fold10_s[8:0]  ^ ({POLY, 1'b0}  & {9{fold10_s[9]}});
    assign reduced_o = fold9_s[7:0]   ^ (POLY          & {8{fold9_s[8]}});

endmodule

// File: rtl/mix_columns.sv
// Shared carry-less byte multiplier; coefficients are at most 4 bits wide so
// the unreduced product fits in 11 bits.
module mix_columns (
    input  logic [7:0]  inputValue,
    input  logic [7:0]  MSDValue,
    output logic [10:0] outputValue
);

    logic unused_msd_s;
    assign unused_msd_s = ^MSDValue[7:4];

    // Shift-and-XOR partial products for each coefficient bit.
    always_comb begin
        outputValue = 11'd0;
        for (int i = 0; i < 4; i++) begin
            outputValue = outputValue ^ (({3'b000, inputValue} << i) & {11{MSDValue[i]}});
        end
    end

endmodule

// File: rtl/mix_columns_sequencer.sv
// Computes AES MixColumns / InvMixColumns over a 128-bit state by time-sharing
// one byte multiplier for 64 cycles between two valid/ready handshakes.
module mix_columns_sequencer
    import mix_columns_sequencer_pkg::*;
#(
    parameter logic [7:0] REDUCTION_POLY = AES_POLY
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inState,
    input  logic         inverse,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outState,
    output logic         busy
);

    seq_state_e   state_q, state_d;
    logic [5:0]   k_q, k_d;
    logic [7:0]   acc_q, acc_d;
    logic [127:0] in_state_q, in_state_d;
    logic         inverse_q, inverse_d;
    logic [127:0] out_state_q, out_state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [7:0]   mul_in_s;
    logic [7:0]   mul_coef_s;
    logic [10:0]  product_s;
    logic [7:0]   reduced_s;
    logic [1:0]   coef_idx_s;
    logic [7:0]   term_s;

    mix_columns u_mul (
        .inputValue  (mul_in_s),
        .MSDValue    (mul_coef_s),
        .outputValue (product_s)
    );

    gf_reduce11 #(
        .POLY (REDUCTION_POLY)
    ) u_reduce (
        .product_i (product_s),
        .reduced_o (reduced_s)
    );

    // k = {column, row, term}; the term picks input row j of the same column.
    assign coef_idx_s = k_q[1:0] - k_q[3:2];
    assign term_s     = acc_q ^ reduced_s;

    // Next-state, datapath and multiplier operand selection.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        in_state_d  = in_state_q;
        inverse_d   = inverse_q;
        out_state_d = out_state_q;
        mul_in_s    = 8'h00;
        mul_coef_s  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (inValid) begin
                    state_d    = ST_RUN;
                    in_state_d = inState;
                    inverse_d  = inverse;
                    k_d        = 6'd0;
                    acc_d      = 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                mul_in_s   = byte_at(in_state_q, {k_q[5:4], k_q[1:0]});
                mul_coef_s = coef_sel(inverse_q, coef_idx_s);
                if (k_q[1:0] == 2'd0) begin
                    acc_d = reduced_s;
                end else begin
                    acc_d = term_s;
                end
                if (k_q[1:0] == 2'd3) begin
                    out_state_d[{4'd15 - k_q[5:2], 3'b000} +: 8] = term_s;
                end else begin
                    out_state_d = out_state_q;
                end
                if (k_q == 6'd63) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            ST_DONE: begin
                if (outReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_RUN);
    end

    // State, datapath and registered handshake flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= 6'd0;
            acc_q       <= 8'h00;
            in_state_q  <= 128'd0;
            inverse_q   <= 1'b0;
            out_state_q <= 128'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            in_state_q  <= in_state_d;
            inverse_q   <= inverse_d;
            out_state_q <= out_state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign busy     = busy_q;
    assign outState = out_state_q;

endmodule

// File: doc/mix_columns_sequencer.md
Name: mix_columns_sequencer

Overview:
- Sequences one shared `mix_columns` byte multiplier to compute a full AES MixColumns or InvMixColumns over a 128-bit state.
- The `mix_columns` multiplier takes `inputValue` (8b) and `MSDValue` (8b constant) and returns an unreduced 11-bit carry-less product on `outputValue`.
- This block issues 64 multiplies, one per cycle (16 output bytes × 4 terms), reduces each product mod the AES polynomial, and XOR-accumulates.
- It sits between the AES round controller and the AddRoundKey stage, with valid/ready handshakes on both sides.

Parameters:
- `REDUCTION_POLY`, 8'h1B, low byte of the field polynomial x^8+x^4+x^3+x+1 used when folding product bits 10..8.

Ports:
- `clock`  input  1  sole clock, rising edge
- `reset`  input  1  asynchronous, active-high reset
- `inValid`  input  1  `inState`/`inverse` are valid
- `inReady`  output  1  block can accept a new state
- `inState`  input  128  state, column-major, byte 0 = [127:120], byte i = s[i%4][i/4]
- `inverse`  input  1  0 = MixColumns, 1 = InvMixColumns; latched at accept
- `outValid`  output  1  `outState` holds a completed result
- `outReady`  input  1  downstream accepts `outState`
- `outState`  output  128  result, same byte ordering as `inState`
- `busy`  output  1  high in RUN

Behaviour:
- Reset (async, any state) forces: state=IDLE, `inReady`=1, `outValid`=0, `busy`=0, `outState`=0, step counter=0, accumulator=0, latched state and mode=0. An operation in flight is abandoned; no partial result is ever presented.
- FSM IDLE:
  - `inReady`=1.
  - Accept occurs on an edge with `inValid`=1: latch `inState` and `inverse`, clear counter and accumulator, go to RUN.
- FSM RUN:
  - `inReady`=0, `busy`=1.
  - 6-bit step counter `k`=0..63; output byte index `b=k[5:2]`, term `j=k[1:0]`, row `r=b%4`, column `c=b/4`.
  - Each cycle, `inputValue` = latched byte s[j][c] and `MSDValue` = coef[(j-r) mod 4].
  - Forward coef = {02,03,01,01}; inverse coef = {0E,0B,0D,09}.
  - Product reduction (combinational, same cycle):
    - If bit 10 is set, XOR `REDUCTION_POLY`<<2 into bits 9..2.
    - Then if bit 9 is set, XOR `REDUCTION_POLY`<<1 into bits 8..1.
    - Then if bit 8 is set, XOR `REDUCTION_POLY` into bits 7..0.
    - Result is 8 bits.
  - Accumulator: at j=0 load the reduced product; otherwise XOR it into the accumulator. At j=3 write (acc ^ product) into result byte b.
  - After step 63 the result register is complete; go to DONE.
- FSM DONE:
  - `outValid`=1, `outState` stable, `inReady`=0.
  - On an edge with `outReady`=1, go to IDLE and clear `outValid`.
  - A new accept is possible on the following edge at the earliest; no overlap.
- Latency: `outValid` rises on the 64th rising edge after the accept edge. Throughput is one state per ≥66 cycles.
- Boundary conditions:
  - `inValid` in RUN/DONE is ignored; no latch occurs.
  - `inState` changes after accept have no effect.
  - `outReady` held high before DONE has no effect.
  - `outReady`=0 holds DONE indefinitely with `outState` unchanged.
  - Counter does not wrap into a second pass; the transition to DONE occurs exactly at k=63.
- `mix_columns` instance inputs are driven to 0 outside RUN.

Decomposition:
- Shared package/include `aes_defs.vh` holds:
  - `AES_POLY` = 8'h1B
  - forward/inverse coefficient constants
  - FSM state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
- One sub-module `gf_reduce11`: 11-bit product in, 8-bit reduced out, purely combinational.
- The controller instantiates `mix_columns` once and `gf_reduce11` once.

Test Plan:
- Forward, column 0 = db 13 53 45, other columns 01 01 01 01 → column 0 out = 8e 4d a1 bc, others 01 01 01 01; `outValid` on edge 64 after accept.
- Forward, state columns {d4 bf 5d 30, f2 0a 22 5c, c6 c6 c6 c6, 01 01 01 01} → {04 66 81 e5, 9f dc 58 9d, c6 c6 c6 c6, 01 01 01 01}.
- Inverse, columns {04 66 81 e5, 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01} → {d4 bf 5d 30, db 13 53 45, f2 0a 22 5c, 01 01 01 01}.
- Backpressure: hold `outReady`=0 for 20 cycles in DONE, toggling `inValid` with a new state → `outState` unchanged, `inReady`=0, no second accept; raise `outReady` → IDLE next edge, then the new state is accepted.
- Reset mid-RUN at k=30 → `outValid`, `busy`, `outState` all 0 immediately (asynchronously); the next accept produces the correct result for its own input only.
- Reduction corner: state all ff, forward → all ff out; state all ff, inverse → all ff out; also checks the bit-10 fold path via coef 0E.
